// File: rtl/seq_detect_ctrl_if.sv
// Bundles the host-facing side of seq_detect_ctrl: configuration, run control,
// serial stream input and status pulses.
// Stream handshake: in_valid qualifies in for exactly the cycle it is high; there is
// no backpressure, so the detector consumes every valid bit while in RUN and drops it otherwise.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TO_W-1:0]    cfg_timeout;
    logic               start;
    logic               abort;
    logic               in_valid;
    logic               in;

    logic               busy;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               timed_out;
    logic               cfg_err;

    // Live view of the configuration registers
    logic [MAX_LEN-1:0] rb_pattern;
    logic [LEN_W-1:0]   rb_len;
    logic               rb_overlap;
    logic [CNT_W-1:0]   rb_target;
    logic [TO_W-1:0]    rb_timeout;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        output start, abort, in_valid, in,
        input  busy, detected, match_count, done, timed_out, cfg_err,
        input  rb_pattern, rb_len, rb_overlap, rb_target, rb_timeout
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        input  start, abort, in_valid, in,
        output busy, detected, match_count, done, timed_out, cfg_err,
        output rb_pattern, rb_len, rb_overlap, rb_target, rb_timeout
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern matcher with an IDLE/ARM/RUN run controller,
// match counting, target completion, inactivity timeout and abort.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_ctrl_if.slave  bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [CNT_W-1:0]   target_r;
    logic [TO_W-1:0]    timeout_r;

    // Only MAX_LEN-1 past bits are kept; the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist, hist_next;
    logic [LEN_W-1:0]   fill, fill_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [TO_W-1:0]    to_cnt, to_next;

    logic               detected_next, done_next, timed_out_next, cfg_err_next;
    logic               load_cfg;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   count_inc;
    logic [TO_W-1:0]    to_inc;
    logic               len_ok;
    logic               match;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_r);
        end
    end

    always_comb begin
        window    = {hist, bus.in};
        fill_inc  = (fill >= len_r) ? len_r : fill + LEN_W'(1);
        count_inc = (&count) ? count : count + CNT_W'(1);
        to_inc    = (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
        len_ok    = (len_r != '0) && (len_r <= LEN_W'(MAX_LEN));
        match     = (state == RUN) && bus.in_valid && (fill_inc == len_r) &&
                    ((window & mask) == (pattern_r & mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        hist_next      = hist;
        fill_next      = fill;
        count_next     = count;
        to_next        = to_cnt;
        detected_next  = 1'b0;
        done_next      = 1'b0;
        timed_out_next = 1'b0;
        cfg_err_next   = 1'b0;
        load_cfg       = 1'b0;

        case (state)
            IDLE: begin
                load_cfg = bus.cfg_we;
                // start is judged against the configuration already held, not one being written now
                if (bus.start) begin
                    if (len_ok) begin
                        state_next = ARM;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end

            ARM: begin
                cfg_err_next = bus.cfg_we;
                hist_next    = '0;
                fill_next    = '0;
                count_next   = '0;
                to_next      = '0;
                state_next   = bus.abort ? IDLE : RUN;
            end

            RUN: begin
                cfg_err_next = bus.cfg_we;
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    if (bus.in_valid) begin
                        hist_next = window[MAX_LEN-2:0];
                        fill_next = fill_inc;
                    end
                    if (match) begin
                        detected_next = 1'b1;
                        count_next    = count_inc;
                        to_next       = '0;
                        if (!overlap_r) begin
                            fill_next = '0;
                        end
                        if ((target_r != '0) && (count_inc == target_r)) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        to_next = to_inc;
                        if ((timeout_r != '0) && (to_inc == timeout_r)) begin
                            timed_out_next = 1'b1;
                            state_next     = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_r       <= MAX_LEN'(8'b0000_1011);
            len_r           <= LEN_W'(4);
            overlap_r       <= 1'b1;
            target_r        <= '0;
            timeout_r       <= '0;
            hist            <= '0;
            fill            <= '0;
            count           <= '0;
            to_cnt          <= '0;
            bus.detected    <= 1'b0;
            bus.done        <= 1'b0;
            bus.timed_out   <= 1'b0;
            bus.cfg_err     <= 1'b0;
        end else begin
            if (load_cfg) begin
                pattern_r <= bus.cfg_pattern;
                len_r     <= bus.cfg_len;
                overlap_r <= bus.cfg_overlap;
                target_r  <= bus.cfg_target;
                timeout_r <= bus.cfg_timeout;
            end
            hist          <= hist_next;
            fill          <= fill_next;
            count         <= count_next;
            to_cnt        <= to_next;
            bus.detected  <= detected_next;
            bus.done      <= done_next;
            bus.timed_out <= timed_out_next;
            bus.cfg_err   <= cfg_err_next;
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.match_count = count;
    assign bus.rb_pattern  = pattern_r;
    assign bus.rb_len      = len_r;
    assign bus.rb_overlap  = overlap_r;
    assign bus.rb_target   = target_r;
    assign bus.rb_timeout  = timeout_r;
    assign dbg_state       = state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a stream-level reference model.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .TO_W(TO_W)) bus ();

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: run phase, config, stream since arm, counters
  int          m_mode;
  bit [7:0]    m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_tgt;
  int          m_to;
  bit          hist_q[$];
  int          m_fresh;
  int          m_count;
  int          m_idle;
  bit          e_det, e_done, e_to, e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1; m_tgt = 0; m_to = 0;
    hist_q.delete(); m_fresh = 0; m_count = 0; m_idle = 0;
    e_det = 0; e_done = 0; e_to = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit hit;
    int nxt;
    e_det = 0; e_done = 0; e_to = 0; e_err = 0;
    nxt = m_mode;
    if (m_mode == 0) begin
      if (bus.start) begin
        if (m_len >= 1 && m_len <= MAX_LEN) nxt = 1;
        else e_err = 1;
      end
      if (bus.cfg_we) begin
        m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len); m_ovl = bus.cfg_overlap;
        m_tgt = int'(bus.cfg_target); m_to = int'(bus.cfg_timeout);
      end
    end else begin
      if (bus.cfg_we) e_err = 1;
      if (m_mode == 1) begin
        hist_q.delete(); m_fresh = 0; m_count = 0; m_idle = 0;
        nxt = bus.abort ? 0 : 2;
      end else if (bus.abort) begin
        nxt = 0;
      end else begin
        hit = 0;
        if (bus.in_valid) begin
          hist_q.push_back(bus.in);
          if (hist_q.size() > MAX_LEN) void'(hist_q.pop_front());
          if (m_fresh < m_len) m_fresh++;
          if (m_fresh == m_len) begin
            hit = 1;
            // last received bit lines up with pattern bit 0
            for (int k = 0; k < m_len; k++)
              if (hist_q[hist_q.size() - 1 - k] != m_pat[k]) hit = 0;
          end
        end
        if (hit) begin
          e_det = 1;
          if (m_count < 255) m_count++;
          m_idle = 0;
          if (!m_ovl) m_fresh = 0;
          if (m_tgt != 0 && m_count == m_tgt) begin
            e_done = 1; nxt = 0;
          end
        end else begin
          if (m_idle < 65535) m_idle++;
          if (m_to != 0 && m_idle == m_to) begin
            e_to = 1; nxt = 0;
          end
        end
      end
    end
    m_mode = nxt;
  endtask

  task automatic compare_all();
    chk("busy",        bus.busy,        m_mode != 0);
    chk("dbg_idle",    dbg_state == 2'd0, m_mode == 0);
    chk("detected",    bus.detected,    e_det);
    chk("done",        bus.done,        e_done);
    chk("timed_out",   bus.timed_out,   e_to);
    chk("cfg_err",     bus.cfg_err,     e_err);
    chk("match_count", bus.match_count, m_count);
    chk("rb_pattern",  bus.rb_pattern,  m_pat);
    chk("rb_len",      bus.rb_len,      m_len);
    chk("rb_overlap",  bus.rb_overlap,  m_ovl);
    chk("rb_target",   bus.rb_target,   m_tgt);
    chk("rb_timeout",  bus.rb_timeout,  m_to);
  endtask

  // driver tasks
  task automatic cycle(input bit we, input bit st, input bit ab, input bit v, input bit d);
    bus.cfg_we = we; bus.start = st; bus.abort = ab; bus.in_valid = v; bus.in = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic load_cfg(input bit [7:0] p, input int l, input bit o, input int t, input int tmo);
    bus.cfg_pattern = p;
    bus.cfg_len     = LEN_W'(l);
    bus.cfg_overlap = o;
    bus.cfg_target  = CNT_W'(t);
    bus.cfg_timeout = TO_W'(tmo);
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic begin_run();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic feed(input bit [15:0] bits, input int n,
                      output bit [15:0] det_m, output bit [15:0] done_m, output bit [15:0] to_m);
    det_m = '0; done_m = '0; to_m = '0;
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 0, 1, bits[n-1-i]);
      det_m[i]  = bus.detected;
      done_m[i] = bus.done;
      to_m[i]   = bus.timed_out;
    end
  endtask

  task automatic reset_mid_cycle();
    #2 rst = 1'b1;
    #1;
    chk("rst_busy",     bus.busy,        0);
    chk("rst_detected", bus.detected,    0);
    chk("rst_done",     bus.done,        0);
    chk("rst_timed_out",bus.timed_out,   0);
    chk("rst_cfg_err",  bus.cfg_err,     0);
    chk("rst_count",    bus.match_count, 0);
    chk("rst_pattern",  bus.rb_pattern,  8'h0B);
    chk("rst_len",      bus.rb_len,      4);
    chk("rst_overlap",  bus.rb_overlap,  1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  bit [15:0] dm, gm, tm;

  initial begin
    rst = 1'b1;
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.cfg_target = '0; bus.cfg_timeout = '0; bus.start = 0; bus.abort = 0;
    bus.in_valid = 0; bus.in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("init_busy",    bus.busy,        0);
    chk("init_count",   bus.match_count, 0);
    chk("init_pattern", bus.rb_pattern,  8'h0B);
    chk("init_len",     bus.rb_len,      4);
    chk("init_overlap", bus.rb_overlap,  1);
    compare_all();

    // defaults, overlapping: stream 1,0,1,1,0,1,1,0,1,1
    begin_run();
    feed(16'b10_1101_1011, 10, dm, gm, tm);
    chk("ovl_det_mask", dm, 16'h0248);
    chk("ovl_count",    bus.match_count, 3);
    chk("ovl_busy",     bus.busy, 1);
    cycle(0, 0, 1, 0, 0);

    // non-overlapping
    load_cfg(8'b0000_1011, 4, 0, 0, 0);
    begin_run();
    feed(16'b10_1101_1011, 10, dm, gm, tm);
    chk("novl_det_mask", dm, 16'h0208);
    chk("novl_count",    bus.match_count, 2);
    cycle(0, 0, 1, 0, 0);

    // target 2, pattern 110
    load_cfg(8'b0000_0110, 3, 1, 2, 0);
    begin_run();
    feed(16'b1_1011_0110, 9, dm, gm, tm);
    chk("tgt_det_mask",  dm, 16'h0024);
    chk("tgt_done_mask", gm, 16'h0020);
    chk("tgt_busy",      bus.busy, 0);
    chk("tgt_count",     bus.match_count, 2);

    // timeout 5 on constant zero
    load_cfg(8'b0000_1011, 4, 1, 0, 5);
    begin_run();
    feed(16'b0, 6, dm, gm, tm);
    chk("to_mask",  tm, 16'h0010);
    chk("to_count", bus.match_count, 0);
    chk("to_busy",  bus.busy, 0);

    // match on the 5th cycle cancels expiry; counter restarts
    begin_run();
    feed(16'b01_0110_0000, 10, dm, gm, tm);
    chk("to2_det_mask", dm, 16'h0010);
    chk("to2_to_mask",  tm, 16'h0200);

    // config write during RUN, then abort on a matching bit
    load_cfg(8'b0000_1011, 4, 1, 0, 0);
    begin_run();
    feed(16'b1011, 4, dm, gm, tm);
    chk("ab_det_mask", dm, 16'h0008);
    bus.cfg_pattern = 8'hFF;
    cycle(1, 0, 0, 0, 0);
    chk("run_we_err",     bus.cfg_err, 1);
    chk("run_we_pattern", bus.rb_pattern, 8'h0B);
    bus.cfg_pattern = 8'h0B;
    feed(16'b01, 2, dm, gm, tm);
    cycle(0, 0, 1, 1, 1);
    chk("ab_detected", bus.detected, 0);
    chk("ab_count",    bus.match_count, 1);
    chk("ab_busy",     bus.busy, 0);

    // illegal length at start
    load_cfg(8'b0000_1011, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("len0_err",  bus.cfg_err, 1);
    chk("len0_busy", bus.busy, 0);

    // legal run then reset mid-stream
    load_cfg(8'b0000_0101, 3, 0, 0, 0);
    begin_run();
    feed(16'b1011, 4, dm, gm, tm);
    chk("pre_rst_det", dm, 16'h0004);
    chk("pre_rst_cnt", bus.match_count, 1);
    reset_mid_cycle();

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      bit we;
      int l;
      we = ($urandom_range(0, 19) == 0);
      if (we) begin
        if ($urandom_range(0, 11) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : 9;
        else if ($urandom_range(0, 3) == 0) l = $urandom_range(5, 8);
        else l = $urandom_range(1, 4);
        bus.cfg_pattern = 8'($urandom);
        bus.cfg_len     = LEN_W'(l);
        bus.cfg_overlap = 1'($urandom_range(0, 1));
        bus.cfg_target  = CNT_W'($urandom_range(0, 4));
        bus.cfg_timeout = TO_W'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12));
      end
      cycle(we, $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      if (c == 1700) reset_mid_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-time controller and programmable serial pattern matcher for single-bit input streams.
- Holds a configurable pattern, length, overlap mode, match target and inactivity timeout, and sequences arm/run/complete.
- Counts matches and reports completion, timeout or abort to a host FSM or register block.
- Replaces fixed-pattern detectors wherever the pattern must change without re-synthesis.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, match counter and target width.
- TO_W, 16, timeout counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  config write strobe; accepted only in IDLE.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is received first, bit 0 last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_target  in  CNT_W  match count that ends the run; 0 = unlimited.
- cfg_timeout  in  TO_W  consecutive match-less RUN cycles before timeout; 0 = disabled.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  end a run immediately.
- in_valid  in  1  in carries a stream bit this cycle.
- in  in  1  serial data bit.
- busy  out  1  high in ARM and RUN.
- detected  out  1  one-cycle pulse per match.
- match_count  out  CNT_W  matches in the current or last run.
- done  out  1  one-cycle pulse when the target is reached.
- timed_out  out  1  one-cycle pulse on timeout exit.
- cfg_err  out  1  one-cycle pulse on a rejected config write or start.

Behaviour:
- All outputs reset to 0.
- Config registers reset to: pattern 8'b0000_1011, len 4, overlap 1, target 0, timeout 0.
- Reset applies at any time, including mid-run: FSM returns to IDLE and history is flushed.
- FSM states: IDLE, ARM, RUN.
- IDLE: cfg_we loads all cfg_* registers.
- IDLE + start:
  - Config legal → ARM next cycle.
  - cfg_len = 0 or cfg_len > MAX_LEN → cfg_err pulse, stay IDLE.
- cfg_we outside IDLE: ignored, cfg_err pulse, config unchanged.
- start outside IDLE: ignored, no error.
- ARM (exactly 1 cycle):
  - Clears history shift register, fill counter, match_count and timeout counter.
  - Input bits are ignored.
  - Next state is RUN.
- RUN, on in_valid:
  - history <= {history[MAX_LEN-2:0], in}.
  - Fill counter increments, saturating at cfg_len.
- Match condition: in_valid, fill (including the current bit) ≥ cfg_len, and the low cfg_len bits of the new history equal the low cfg_len bits of the pattern.
- On match:
  - detected pulses the following cycle (latency 1).
  - match_count increments, saturating at all-ones.
  - Timeout counter clears.
  - If cfg_overlap = 0, the fill counter clears, so the next match needs cfg_len fresh bits.
- Timeout counter:
  - Increments every RUN cycle without a match, whether or not in_valid is high.
  - When it reaches cfg_timeout (nonzero): timed_out pulses the next cycle and the FSM goes to IDLE.
- Target: when match_count reaches cfg_target (nonzero), done pulses the next cycle (together with the final detected) and the FSM goes to IDLE.
- abort in ARM or RUN: go to IDLE next cycle with no done or timed_out pulse. A match in the abort cycle is discarded.
- Priority in one cycle: abort > match > timeout. A match in the expiry cycle cancels the timeout.
- match_count holds its value in IDLE until the next ARM.
- busy drops in the same cycle done or timed_out pulses.

Test Plan:
- Reset defaults, start, stream 1,0,1,1,0,1,1,0,1,1 (in_valid=1 every cycle) → detected after bits 4, 7 and 10; match_count=3; busy stays high.
- Same stream with cfg_overlap=0 → detected after bits 4 and 10 only; match_count=2.
- cfg_target=2, pattern 3'b110 (len 3), stream 1,1,0,1,1,0,1,1,0 → done and detected pulse together after bit 6; busy low; match_count stays 2; bits 7-9 ignored.
- cfg_timeout=5, constant 0 input → timed_out pulses the cycle after the 5th RUN cycle; match_count=0; state IDLE. Repeat with a match on the 5th cycle → no timeout; counter restarts.
- During RUN: cfg_we → cfg_err pulse, config readback unchanged. abort asserted on a matching bit → no detected, match_count unchanged, IDLE next cycle.
- cfg_len=0 then start → cfg_err, busy stays 0. Legal run, then rst asserted mid-stream → all outputs 0 immediately; config returns to defaults.
